x_bram_fifo_ctrl: RTL and testbench

//  Single-clock FIFO controller that drives a 2K x 9 dual-port block RAM (S9_S9 style).

---
 rtl/x_bram_fifo_ctrl.sv | 130 +++++++++++++
 tb/tb_x_bram_fifo_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/x_bram_fifo_ctrl.sv
// Single-clock FIFO controller for a 2K x 9 dual-port block RAM (port A writes, port B reads).
// Optional sticky overflow/underflow flags are enabled by defining X_BRAM_FIFO_ERR_FLAGS_EN.
module x_bram_fifo_ctrl #(
  parameter int ADDR_W     = 11,
  parameter int AFULL_LVL  = 2040,
  parameter int AEMPTY_LVL = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              WR_EN,
  input  logic [8:0]        WR_DATA,
  output logic              FULL,
  output logic              ALMOST_FULL,
  input  logic              RD_EN,
  output logic [8:0]        RD_DATA,
  output logic              RD_VALID,
  output logic              EMPTY,
  output logic              ALMOST_EMPTY,
  output logic [ADDR_W:0]   COUNT,
  output logic [ADDR_W-1:0] RAM_ADDRA,
  output logic [7:0]        RAM_DIA,
  output logic              RAM_DIPA,
  output logic              RAM_ENA,
  output logic              RAM_WEA,
  output logic [ADDR_W-1:0] RAM_ADDRB,
  output logic              RAM_ENB,
  input  logic [7:0]        RAM_DOB,
  input  logic              RAM_DOPB
`ifdef X_BRAM_FIFO_ERR_FLAGS_EN
  ,
  input  logic              ERR_CLR,
  output logic              OVF,
  output logic              UNF
`endif
);

  localparam logic [ADDR_W:0]   DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   AFULL_C  = AFULL_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0]   AEMPTY_C = AEMPTY_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_next;
  logic              full_q;
  logic              empty_q;
  logic              afull_q;
  logic              aempty_q;
  logic              vld_p1;
  logic              push_ok;
  logic              pop_ok;

  // Gating with RST_N keeps both RAM ports idle while reset is held.
  assign push_ok = WR_EN & ~full_q & RST_N;
  assign pop_ok  = RD_EN & ~empty_q & RST_N;

  assign RAM_ENA   = push_ok;
  assign RAM_WEA   = push_ok;
  assign RAM_ADDRA = wptr;
  assign RAM_DIA   = WR_DATA[7:0];
  assign RAM_DIPA  = WR_DATA[8];
  assign RAM_ENB   = pop_ok;
  assign RAM_ADDRB = rptr;

  assign FULL         = full_q;
  assign EMPTY        = empty_q;
  assign ALMOST_FULL  = afull_q;
  assign ALMOST_EMPTY = aempty_q;
  assign COUNT        = count_q;
  assign RD_VALID     = vld_p1;
  assign RD_DATA      = {RAM_DOPB, RAM_DOB};

  always_comb begin
    count_next = count_q;
    if (push_ok && !pop_ok) begin
      count_next = count_q + CNT_ONE;
    end else if (!push_ok && pop_ok) begin
      count_next = count_q - CNT_ONE;
    end
  end

  // Stage p0 -> p1: pointers, occupancy, flags and the read strobe all register here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr     <= '0;
      rptr     <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      vld_p1   <= 1'b0;
    end else begin
      if (push_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (pop_ok) begin
        rptr <= rptr + PTR_ONE;
      end
      count_q  <= count_next;
      full_q   <= (count_next == DEPTH);
      empty_q  <= (count_next == '0);
      afull_q  <= (count_next >= AFULL_C);
      aempty_q <= (count_next <= AEMPTY_C);
      vld_p1   <= pop_ok;
    end
  end

`ifdef X_BRAM_FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic unf_q;

  assign OVF = ovf_q;
  assign UNF = unf_q;

  // A new error in the clearing cycle wins over ERR_CLR.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (ovf_q & ~ERR_CLR) | (WR_EN & full_q);
      unf_q <= (unf_q & ~ERR_CLR) | (RD_EN & empty_q);
    end
  end
`endif

endmodule

// File: tb/tb_x_bram_fifo_ctrl.sv
// Bench for x_bram_fifo_ctrl: behavioural 2K x 9 RAM, directed vector table plus multi-cycle sequences.
module tb_x_bram_fifo_ctrl;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 2048;

  logic              CLK;
  logic              RST_N;
  logic              WR_EN;
  logic [8:0]        WR_DATA;
  logic              FULL;
  logic              ALMOST_FULL;
  logic              RD_EN;
  logic [8:0]        RD_DATA;
  logic              RD_VALID;
  logic              EMPTY;
  logic              ALMOST_EMPTY;
  logic [ADDR_W:0]   COUNT;
  logic [ADDR_W-1:0] RAM_ADDRA;
  logic [7:0]        RAM_DIA;
  logic              RAM_DIPA;
  logic              RAM_ENA;
  logic              RAM_WEA;
  logic [ADDR_W-1:0] RAM_ADDRB;
  logic              RAM_ENB;
  logic [7:0]        RAM_DOB;
  logic              RAM_DOPB;
`ifdef X_BRAM_FIFO_ERR_FLAGS_EN
  logic              ERR_CLR;
  logic              OVF;
  logic              UNF;
`endif

  x_bram_fifo_ctrl #(.ADDR_W(ADDR_W), .AFULL_LVL(2040), .AEMPTY_LVL(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .WR_EN(WR_EN), .WR_DATA(WR_DATA), .FULL(FULL),
    .ALMOST_FULL(ALMOST_FULL), .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
    .EMPTY(EMPTY), .ALMOST_EMPTY(ALMOST_EMPTY), .COUNT(COUNT), .RAM_ADDRA(RAM_ADDRA),
    .RAM_DIA(RAM_DIA), .RAM_DIPA(RAM_DIPA), .RAM_ENA(RAM_ENA), .RAM_WEA(RAM_WEA),
    .RAM_ADDRB(RAM_ADDRB), .RAM_ENB(RAM_ENB), .RAM_DOB(RAM_DOB), .RAM_DOPB(RAM_DOPB)
`ifdef X_BRAM_FIFO_ERR_FLAGS_EN
    , .ERR_CLR(ERR_CLR), .OVF(OVF), .UNF(UNF)
`endif
  );

  // Behavioural S9_S9 block RAM: synchronous write on A, registered read on B.
  logic [8:0] mem [0:DEPTH-1];
  always @(posedge CLK) begin
    if (RAM_ENA && RAM_WEA) mem[RAM_ADDRA] <= {RAM_DIPA, RAM_DIA};
    if (RAM_ENB) {RAM_DOPB, RAM_DOB} <= mem[RAM_ADDRB];
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_vec;
  int n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic       wr;
    logic [8:0] wd;
    logic       rd;
    logic       ena;
    logic       enb;
    logic [11:0] cnt;
    logic       empty;
    logic       full;
    logic       vld;
    logic [8:0] data;
  } vec_t;

  vec_t tbl [10];

  // Small reference model for the long sequences.
  logic [8:0]        q [$];
  int                exp_cnt;
  logic [ADDR_W-1:0] exp_wa;
  logic [ADDR_W-1:0] exp_ra;
  logic [8:0]        exp_data;

  task automatic do_reset();
    RST_N = 1'b0;
    WR_EN = 1'b1;
    RD_EN = 1'b1;
    #1;
    chk("rst_ram_ena", RAM_ENA, 0);
    chk("rst_ram_enb", RAM_ENB, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_empty", EMPTY, 1);
    chk("rst_aempty", ALMOST_EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_afull", ALMOST_FULL, 0);
    chk("rst_rd_valid", RD_VALID, 0);
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_held_count", COUNT, 0);
    RST_N = 1'b1;
    WR_EN = 1'b0;
    RD_EN = 1'b0;
    q.delete();
    exp_cnt = 0;
    exp_wa  = '0;
    exp_ra  = '0;
  endtask

  task automatic do_cycle(input logic wr, input logic [8:0] wd, input logic rd);
    logic push;
    logic pop;
    WR_EN   = wr;
    WR_DATA = wd;
    RD_EN   = rd;
    push = wr && (exp_cnt != DEPTH);
    pop  = rd && (exp_cnt != 0);
    #1;
    chk("ram_ena", RAM_ENA, push);
    chk("ram_wea", RAM_WEA, push);
    chk("ram_enb", RAM_ENB, pop);
    if (push) chk("ram_addra", RAM_ADDRA, exp_wa);
    if (pop)  chk("ram_addrb", RAM_ADDRB, exp_ra);
    @(posedge CLK);
    #1;
    if (push) begin
      q.push_back(wd);
      exp_wa = exp_wa + 1'b1;
      exp_cnt++;
    end
    if (pop) begin
      exp_data = q.pop_front();
      exp_ra = exp_ra + 1'b1;
      exp_cnt--;
    end
    chk("count", COUNT, exp_cnt);
    chk("empty", EMPTY, exp_cnt == 0);
    chk("full", FULL, exp_cnt == DEPTH);
    chk("afull", ALMOST_FULL, exp_cnt >= 2040);
    chk("aempty", ALMOST_EMPTY, exp_cnt <= 8);
    chk("rd_valid", RD_VALID, pop);
    if (pop) chk("rd_data", RD_DATA, exp_data);
    WR_EN = 1'b0;
    RD_EN = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    RST_N   = 1'b1;
    WR_EN   = 1'b0;
    RD_EN   = 1'b0;
    WR_DATA = '0;
`ifdef X_BRAM_FIFO_ERR_FLAGS_EN
    ERR_CLR = 1'b0;
`endif
    //            wr    wd      rd    ena   enb   cnt     empty full  vld   data
    tbl[0] = '{1'b1, 9'h101, 1'b0, 1'b1, 1'b0, 12'd1, 1'b0, 1'b0, 1'b0, 9'h000};
    tbl[1] = '{1'b1, 9'h0AA, 1'b0, 1'b1, 1'b0, 12'd2, 1'b0, 1'b0, 1'b0, 9'h000};
    tbl[2] = '{1'b1, 9'h055, 1'b0, 1'b1, 1'b0, 12'd3, 1'b0, 1'b0, 1'b0, 9'h000};
    tbl[3] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 12'd2, 1'b0, 1'b0, 1'b1, 9'h101};
    tbl[4] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 12'd1, 1'b0, 1'b0, 1'b1, 9'h0AA};
    tbl[5] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 12'd0, 1'b1, 1'b0, 1'b1, 9'h055};
    tbl[6] = '{1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 9'h000};
    tbl[7] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0, 12'd0, 1'b1, 1'b0, 1'b0, 9'h000};
    tbl[8] = '{1'b1, 9'h1FF, 1'b1, 1'b1, 1'b0, 12'd1, 1'b0, 1'b0, 1'b0, 9'h000};
    tbl[9] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 12'd0, 1'b1, 1'b0, 1'b1, 9'h1FF};

    @(posedge CLK);
    #1;
    do_reset();

    for (int i = 0; i < 10; i++) begin
      WR_EN   = tbl[i].wr;
      WR_DATA = tbl[i].wd;
      RD_EN   = tbl[i].rd;
      #1;
      chk($sformatf("v%0d_ena", i), RAM_ENA, tbl[i].ena);
      chk($sformatf("v%0d_enb", i), RAM_ENB, tbl[i].enb);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_count", i), COUNT, tbl[i].cnt);
      chk($sformatf("v%0d_empty", i), EMPTY, tbl[i].empty);
      chk($sformatf("v%0d_full", i), FULL, tbl[i].full);
      chk($sformatf("v%0d_rd_valid", i), RD_VALID, tbl[i].vld);
      if (tbl[i].vld) chk($sformatf("v%0d_rd_data", i), RD_DATA, tbl[i].data);
    end
    WR_EN = 1'b0;
    RD_EN = 1'b0;

    // Fill to full, overflow attempt, push+pop while full, then drain.
    do_reset();
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 9'(i * 7 + 3), 1'b0);
    chk("fill_count", COUNT, 2048);
    chk("fill_full", FULL, 1);
    do_cycle(1'b1, 9'h1AB, 1'b0);
    chk("ovf_push_count", COUNT, 2048);
`ifdef X_BRAM_FIFO_ERR_FLAGS_EN
    chk("ovf_flag", OVF, 1);
    ERR_CLR = 1'b1;
    @(posedge CLK);
    #1;
    ERR_CLR = 1'b0;
    chk("ovf_cleared", OVF, 0);
`endif
    do_cycle(1'b1, 9'h1CD, 1'b1);
    chk("full_both_count", COUNT, 2047);
    while (exp_cnt > 0) do_cycle(1'b0, 9'h000, 1'b1);
    chk("drain_empty", EMPTY, 1);
`ifdef X_BRAM_FIFO_ERR_FLAGS_EN
    do_cycle(1'b0, 9'h000, 1'b1);
    chk("unf_flag", UNF, 1);
`endif

    // Simultaneous push/pop at COUNT=5 holds occupancy.
    do_reset();
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 9'h040 + 9'(i), 1'b0);
    for (int i = 0; i < 10; i++) do_cycle(1'b1, 9'h150 + 9'(i), 1'b1);
    chk("both_count5", COUNT, 5);
    while (exp_cnt > 0) do_cycle(1'b0, 9'h000, 1'b1);

    // Long stream across the pointer wrap.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      do_cycle(1'b1, 9'(i), 1'b1);
      if (i == 2047) chk("wrap_addra", RAM_ADDRA, 0);
    end
    while (exp_cnt > 0) do_cycle(1'b0, 9'h000, 1'b1);
    chk("wrap_addrb", RAM_ADDRB, 3000 % DEPTH);

    // Asynchronous reset right after a pop drops the in-flight read.
    do_reset();
    do_cycle(1'b1, 9'h0F0, 1'b0);
    do_cycle(1'b1, 9'h10F, 1'b0);
    do_cycle(1'b0, 9'h000, 1'b1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("async_rd_valid", RD_VALID, 0);
    chk("async_count", COUNT, 0);
    chk("async_empty", EMPTY, 1);
    @(posedge CLK);
    #1;
    do_reset();
    chk("post_rst_addra", RAM_ADDRA, 0);
    do_cycle(1'b1, 9'h123, 1'b0);
    do_cycle(1'b0, 9'h000, 1'b1);
    chk("post_rst_data", RD_DATA, 9'h123);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
